// File: rtl/sound_arbiter.sv
// rtl/sound_arbiter.sv - priority arbiter for the single tone output: pending requests, preemption, gap, ON/OFF mode
module sound_arbiter #(
    parameter int BAD_HALF  = 40,
    parameter int GOOD_HALF = 20,
    parameter int DIR_HALF  = 10,
    parameter int BAD_DUR   = 400,
    parameter int GOOD_DUR  = 200,
    parameter int DIR_DUR   = 50,
    parameter int GAP_DUR   = 16,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    input  logic       goodColl,
    input  logic       badColl,
    input  logic [3:0] direction,
    output logic       playSound,
    output logic       toneOut,
    output logic [1:0] soundId,
    output logic       mode_o,
    output logic       busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [1:0] ID_DIR  = 2'd1;
    localparam logic [1:0] ID_GOOD = 2'd2;
    localparam logic [1:0] ID_BAD  = 2'd3;

    logic [1:0]       state, state_n;
    logic [1:0]       sid_n, best, grant_id;
    logic [CNT_W-1:0] dur_cnt, dur_n;
    logic [CNT_W-1:0] half_cnt, half_n;
    logic             tone_n;
    logic             pend_bad, pend_good, pend_dir;
    logic             button_prev;
    logic [3:0]       prev_dir;
    logic             dir_evt;

    function automatic logic [CNT_W-1:0] dur_of(input logic [1:0] id);
        case (id)
            ID_BAD:  dur_of = CNT_W'(BAD_DUR);
            ID_GOOD: dur_of = CNT_W'(GOOD_DUR);
            default: dur_of = CNT_W'(DIR_DUR);
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] half_of(input logic [1:0] id);
        case (id)
            ID_BAD:  half_of = CNT_W'(BAD_HALF);
            ID_GOOD: half_of = CNT_W'(GOOD_HALF);
            default: half_of = CNT_W'(DIR_HALF);
        endcase
    endfunction

    assign dir_evt = (direction != 4'd0) && (direction != prev_dir);

    // Sound ids are numbered in priority order, so a plain compare decides preemption.
    always_comb begin
        if (pend_bad)       best = ID_BAD;
        else if (pend_good) best = ID_GOOD;
        else if (pend_dir)  best = ID_DIR;
        else                best = 2'd0;
    end

    always_comb begin
        state_n  = state;
        sid_n    = soundId;
        dur_n    = dur_cnt;
        half_n   = half_cnt;
        tone_n   = toneOut;
        grant_id = 2'd0;
        if (!mode_o) begin
            state_n = S_IDLE;
            sid_n   = 2'd0;
            tone_n  = 1'b0;
            dur_n   = '0;
            half_n  = '0;
        end else begin
            case (state)
                S_IDLE: grant_id = best;
                S_PLAY: begin
                    if (best > soundId) begin
                        grant_id = best;
                    end else if (dur_cnt == CNT_W'(1)) begin
                        state_n = S_GAP;
                        sid_n   = 2'd0;
                        tone_n  = 1'b0;
                        dur_n   = CNT_W'(GAP_DUR);
                        half_n  = '0;
                    end else begin
                        dur_n = dur_cnt - CNT_W'(1);
                        if (half_cnt == CNT_W'(1)) begin
                            tone_n = ~toneOut;
                            half_n = half_of(soundId);
                        end else begin
                            half_n = half_cnt - CNT_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (dur_cnt == CNT_W'(1)) begin
                        if (best != 2'd0) begin
                            grant_id = best;
                        end else begin
                            state_n = S_IDLE;
                            dur_n   = '0;
                        end
                    end else begin
                        dur_n = dur_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    sid_n   = 2'd0;
                    tone_n  = 1'b0;
                end
            endcase
            if (grant_id != 2'd0) begin
                state_n = S_PLAY;
                sid_n   = grant_id;
                dur_n   = dur_of(grant_id);
                half_n  = half_of(grant_id);
                tone_n  = 1'b1;
            end
        end
    end

    // A granted flag clears even if its request is high again on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            mode_o      <= 1'b1;
            pend_bad    <= 1'b0;
            pend_good   <= 1'b0;
            pend_dir    <= 1'b0;
            prev_dir    <= 4'd0;
            button_prev <= 1'b0;
            dur_cnt     <= '0;
            half_cnt    <= '0;
            playSound   <= 1'b0;
            toneOut     <= 1'b0;
            soundId     <= 2'd0;
            busy        <= 1'b0;
        end else begin
            button_prev <= button;
            prev_dir    <= direction;
            if (button && !button_prev) mode_o <= ~mode_o;
            pend_bad  <= mode_o && (pend_bad  || badColl)  && (grant_id != ID_BAD);
            pend_good <= mode_o && (pend_good || goodColl) && (grant_id != ID_GOOD);
            pend_dir  <= mode_o && (pend_dir  || dir_evt)  && (grant_id != ID_DIR);
            state     <= state_n;
            dur_cnt   <= dur_n;
            half_cnt  <= half_n;
            soundId   <= sid_n;
            toneOut   <= tone_n;
            playSound <= (state_n == S_PLAY);
            busy      <= (state_n != S_IDLE);
        end
    end

endmodule

// File: doc/sound_arbiter.md
Name: sound_arbiter

Overview:
Schedules the single piezo/tone output among the game's sound requesters: bad collision, good collision and snake direction change. Holds pending requests, grants by fixed priority with preemption, times tone duration and pitch, and enforces a silent gap between sounds. Also owns the sound ON/OFF mode toggled by the player button. Sits between the game-logic collision/direction signals and the speaker pin.

Parameters:
BAD_HALF, 40, tone half-period in clk cycles for the bad-collision sound
GOOD_HALF, 20, tone half-period for the good-collision sound
DIR_HALF, 10, tone half-period for the direction-change sound
BAD_DUR, 400, PLAY length in cycles for bad
GOOD_DUR, 200, PLAY length for good
DIR_DUR, 50, PLAY length for direction
GAP_DUR, 16, silent cycles after a sound completes
CNT_W, 16, width of the duration and half-period counters; all *_DUR and *_HALF values are at least 1 and below 2**CNT_W

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
button  in  1  mode toggle, level, synchronous to clk
goodColl  in  1  good-collision request, level
badColl  in  1  bad-collision request, level
direction  in  4  one-hot snake direction, 0 = none
playSound  out  1  high while in PLAY
toneOut  out  1  square wave to speaker, 0 when not in PLAY
soundId  out  2  0 none, 1 dir, 2 good, 3 bad; the sound currently in PLAY
mode_o  out  1  1 = ON, 0 = OFF
busy  out  1  high in PLAY or GAP

Behaviour:
- Reset (async, any state): state IDLE, mode_o=1, all pending flags 0, prevDir=0, buttonPrev=0, counters 0, playSound=0, toneOut=0, soundId=0, busy=0.
- Button: on a rising edge (button=1 and buttonPrev=0, registered), mode_o toggles. Holding the button gives exactly one toggle.
- Direction event: direction!=0 and direction!=prevDir. prevDir is registered from direction every cycle.
- Pending flags pendBad, pendGood, pendDir: each is set at the edge where its request is sampled high while mode_o=1. Setting is idempotent, so there is no queue depth and repeated requests merge. A flag clears at the edge where its sound enters PLAY. A new request for the same sound at that same edge is absorbed.
- Priority: bad > good > dir.
- FSM states are IDLE, PLAY and GAP.
- IDLE -> PLAY: the highest pending flag is granted. Latency is fixed: request sampled at edge k, playSound=1 after edge k+1.
- PLAY entry loads the duration counter with *_DUR and the half-period counter with *_HALF. toneOut starts at 1 and toggles each time the half counter expires, then the half counter reloads.
- PLAY lasts exactly *_DUR cycles, then the FSM goes to GAP.
- Preemption: in PLAY, a pending flag of strictly higher priority than soundId moves the FSM to PLAY of that sound at the next edge. Counters reload, there is no gap, and the preempted sound is dropped. Equal or lower priority requests stay pending.
- GAP lasts exactly GAP_DUR cycles with toneOut=0. At its end the FSM enters PLAY of the highest pending sound if one exists, otherwise IDLE. Preemption does not apply in GAP; requests wait for GAP to finish.
- Mode OFF: requests are ignored and all pending flags are cleared. From PLAY or GAP the FSM returns to IDLE at the next edge (toneOut=0, soundId=0). IDLE is held until mode_o=1.
- Simultaneous bad+good+dir in one cycle: all three flags set. Bad plays first, then good after a gap, then dir after a gap.
- Outputs are registered and glitch-free. soundId=0 outside PLAY.

Test Plan:
- Reset mid-PLAY: with small params (DUR=8, HALF=2, GAP=3), assert rst during PLAY -> outputs are 0 and mode_o=1 immediately, with no clock edge required.
- Single goodColl pulse (1 cycle), GOOD_DUR=8, GOOD_HALF=2 -> playSound high 2 edges later for exactly 8 cycles; toneOut runs 1,1,0,0,1,1,0,0; soundId=2; busy stays high through 3 GAP cycles, then IDLE.
- badColl, goodColl and direction=0001 in the same cycle -> soundId sequence 3, 2, 1, each separated by 3-cycle gaps; each flag is cleared on its PLAY entry.
- dir playing (DIR_DUR=20), badColl arrives at PLAY cycle 5 -> soundId becomes 3 two edges later with counters reloaded and no gap; dir is not replayed.
- direction held at 0010 for 10 cycles -> exactly one dir sound. direction 0010 then 0100 -> a second dir event.
- Button held 5 cycles -> mode_o 1 to 0 once and an active sound aborts to IDLE. goodColl while OFF -> no sound, even after mode returns ON.
